// File: rtl/mc_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle of control/status signals between the multi-cycle MIPS control
// sequencer and the shared datapath.
//
// Signals:
//   opcode[5:0]     IR[31:26], sampled by the sequencer in DECODE
//   zero            ALU zero flag
//   mem_ready       memory completes the current access this cycle
//   pc_write        unconditional PC load
//   pc_write_cond   PC load if zero
//   pc_en           pc_write | (pc_write_cond & zero)
//   iord            memory address source: 0 = PC, 1 = ALUOut
//   mem_read        memory read request
//   mem_write       memory write request
//   ir_write        IR load
//   reg_dst         write register: 1 = rd, 0 = rt
//   mem_to_reg      write data: 1 = MDR, 0 = ALUOut
//   reg_write       register-file write enable
//   alu_src_a       0 = PC, 1 = A
//   alu_src_b[1:0]  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op[1:0]     00 add, 01 sub, 10 funct
//   pc_source[1:0]  00 = ALU result, 01 = ALUOut, 10 = jump target
//   state[3:0]      current sequencer state code (debug)
//   err             sticky trap flag
//
// Modports: master = sequencer, slave = datapath side.
// ----------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       err;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, state, err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, state, err
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle MIPS control sequencer. Steps the shared datapath through
// FETCH/DECODE/EXECUTE/MEM/WB for R-type, lw, sw and beq, waits on the memory
// ready handshake and traps illegal opcodes and memory timeouts into a sticky
// ERR state that only rst leaves.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset (all outputs forced to 0 while high)
//   bus   mc_ctrl_fsm_if.master: opcode/zero/mem_ready in, datapath controls,
//         state and err out
//
// Parameters:
//   MEM_TIMEOUT  wait cycles allowed per memory access (0 = no timeout)
//
// Optional feature:
//   MC_CTRL_JUMP_EN  when defined, opcode 2 runs a 3-cycle jump through the
//                    JUMP state; otherwise opcode 2 is illegal and traps.
// ----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
`ifdef MC_CTRL_JUMP_EN
    ST_JUMP     = 4'd9,
`endif
    ST_ERR      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // The counter holds the number of wait cycles already spent; the trap fires
  // on the wait cycle that would bring it to MEM_TIMEOUT.
  localparam logic [7:0] TO_LAST = (MEM_TIMEOUT == 32'd0) ? 8'd0 : 8'(MEM_TIMEOUT - 32'd1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] opcode_r;
  logic [7:0] wait_cnt_r;
  logic       wait_st_s;
  logic       timeout_s;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_source_s;
  logic       err_s;

  assign wait_st_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
  // mem_ready on the deadline cycle wins over the trap.
  assign timeout_s = (MEM_TIMEOUT != 32'd0) && !bus.mem_ready && (wait_cnt_r == TO_LAST);

  // State register, latched opcode and memory wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      opcode_r   <= 6'd0;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        opcode_r <= bus.opcode;
      end else begin
        opcode_r <= opcode_r;
      end
      // Any state change clears the counter, covering entry to every wait state.
      if (state_nxt_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if (wait_st_s && !bus.mem_ready && (wait_cnt_r != 8'hFF)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.mem_ready)  state_nxt_s = ST_DECODE;
        else if (timeout_s) state_nxt_s = ST_ERR;
        else                state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_nxt_s = ST_EXEC_R;
          OP_LW, OP_SW: state_nxt_s = ST_MEM_ADDR;
          OP_BEQ:       state_nxt_s = ST_BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_nxt_s = ST_JUMP;
`endif
          default:      state_nxt_s = ST_ERR;
        endcase
      end
      ST_MEM_ADDR: begin
        case (opcode_r)
          OP_LW:   state_nxt_s = ST_MEM_RD;
          OP_SW:   state_nxt_s = ST_MEM_WR;
          default: state_nxt_s = ST_ERR;
        endcase
      end
      ST_MEM_RD: begin
        if (bus.mem_ready)  state_nxt_s = ST_MEM_WB;
        else if (timeout_s) state_nxt_s = ST_ERR;
        else                state_nxt_s = ST_MEM_RD;
      end
      ST_MEM_WB: state_nxt_s = ST_FETCH;
      ST_MEM_WR: begin
        if (bus.mem_ready)  state_nxt_s = ST_FETCH;
        else if (timeout_s) state_nxt_s = ST_ERR;
        else                state_nxt_s = ST_MEM_WR;
      end
      ST_EXEC_R: state_nxt_s = ST_R_WB;
      ST_R_WB:   state_nxt_s = ST_FETCH;
      ST_BRANCH: state_nxt_s = ST_FETCH;
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP:   state_nxt_s = ST_FETCH;
`endif
      ST_ERR:    state_nxt_s = ST_ERR;
      default:   state_nxt_s = ST_ERR;
    endcase
  end

  // Output decode from the current state (FETCH strobes qualified by mem_ready).
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_source_s     = 2'b00;
    err_s           = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
      end
      ST_DECODE: begin
        alu_src_b_s = 2'b11;
      end
      ST_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      ST_MEM_RD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      ST_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
      end
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
      end
`endif
      ST_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  // rst gates every output combinationally so no strobe leaks while reset is held.
  assign bus.pc_write      = ~rst & pc_write_s;
  assign bus.pc_write_cond = ~rst & pc_write_cond_s;
  assign bus.pc_en         = ~rst & (pc_write_s | (pc_write_cond_s & bus.zero));
  assign bus.iord          = ~rst & iord_s;
  assign bus.mem_read      = ~rst & mem_read_s;
  assign bus.mem_write     = ~rst & mem_write_s;
  assign bus.ir_write      = ~rst & ir_write_s;
  assign bus.reg_dst       = ~rst & reg_dst_s;
  assign bus.mem_to_reg    = ~rst & mem_to_reg_s;
  assign bus.reg_write     = ~rst & reg_write_s;
  assign bus.alu_src_a     = ~rst & alu_src_a_s;
  assign bus.alu_src_b     = rst ? 2'b00 : alu_src_b_s;
  assign bus.alu_op        = rst ? 2'b00 : alu_op_s;
  assign bus.pc_source     = rst ? 2'b00 : pc_source_s;
  assign bus.err           = ~rst & err_s;
  assign bus.state         = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT = 15). Inputs are changed 1 time
// unit after the rising edge and outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_ctrl_fsm_if bif ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  always #5 clk = ~clk;

  // All 1-bit/2-bit outputs except state, packed for whole-vector checks.
  function automatic logic [17:0] all_outs();
    return {bif.pc_write, bif.pc_write_cond, bif.pc_en, bif.iord, bif.mem_read,
            bif.mem_write, bif.ir_write, bif.reg_dst, bif.mem_to_reg, bif.reg_write,
            bif.alu_src_a, bif.alu_src_b, bif.alu_op, bif.pc_source, bif.err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave a gap before inputs change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    bif.opcode    = 6'd0;
    bif.zero      = 1'b0;
    bif.mem_ready = 1'b1;

    // Reset held: every output 0 even though FETCH with mem_ready would strobe.
    cyc(); cyc(); settle();
    chk("rst_state", 32'(bif.state), 32'd0);
    chk("rst_outs", 32'(all_outs()), 32'd0);

    // R-type: 0,1,6,7,0.
    rst = 1'b0; settle();
    chk("r_fetch_state", 32'(bif.state), 32'd0);
    // FETCH w/ ready: pc_write,pc_en,mem_read,ir_write, alu_src_b=01.
    chk("r_fetch_outs", 32'(all_outs()), 32'(18'b1_0_1_0_1_0_1_0_0_0_0_01_00_00_0));
    cyc(); chk("r_decode_state", 32'(bif.state), 32'd1);
    chk("r_decode_srcb", 32'(bif.alu_src_b), 32'd3);
    cyc(); chk("r_exec_state", 32'(bif.state), 32'd6);
    chk("r_exec_aluop", 32'(bif.alu_op), 32'd2);
    cyc(); chk("r_wb_state", 32'(bif.state), 32'd7);
    chk("r_wb_outs", 32'(all_outs()), 32'(18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0));
    cyc(); chk("r_done_state", 32'(bif.state), 32'd0);

    // lw with 3 wait cycles in MEM_RD: 0,1,2,3,3,3,3,4,0.
    bif.opcode = 6'd35;
    cyc(); chk("lw_decode", 32'(bif.state), 32'd1);
    cyc(); bif.mem_ready = 1'b0; settle();
    chk("lw_addr", 32'(bif.state), 32'd2);
    chk("lw_addr_srcb", 32'(bif.alu_src_b), 32'd2);
    cyc(); chk("lw_rd_state", 32'(bif.state), 32'd3);
    chk("lw_rd_iord", 32'(bif.iord), 32'd1);
    chk("lw_rd_memread", 32'(bif.mem_read), 32'd1);
    cyc(); chk("lw_rd_w2", 32'(bif.state), 32'd3);
    cyc(); chk("lw_rd_w3", 32'(bif.state), 32'd3);
    cyc(); bif.mem_ready = 1'b1; settle();
    chk("lw_rd_last", 32'(bif.state), 32'd3);
    cyc(); chk("lw_wb_state", 32'(bif.state), 32'd4);
    chk("lw_wb_outs", 32'(all_outs()), 32'(18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0));
    cyc(); chk("lw_done", 32'(bif.state), 32'd0);

    // beq taken then not taken: 3 cycles each.
    bif.opcode = 6'd4; bif.zero = 1'b1;
    cyc(); cyc(); chk("beq1_state", 32'(bif.state), 32'd8);
    chk("beq1_pcen", 32'(bif.pc_en), 32'd1);
    chk("beq1_aluop", 32'(bif.alu_op), 32'd1);
    chk("beq1_pcsrc", 32'(bif.pc_source), 32'd1);
    chk("beq1_pwc", 32'(bif.pc_write_cond), 32'd1);
    cyc(); chk("beq1_done", 32'(bif.state), 32'd0);
    bif.zero = 1'b0;
    cyc(); cyc(); chk("beq0_state", 32'(bif.state), 32'd8);
    chk("beq0_pcen", 32'(bif.pc_en), 32'd0);
    cyc(); chk("beq0_done", 32'(bif.state), 32'd0);

    // sw with mem_ready stuck low: 15 cycles in MEM_WR, then ERR.
    bif.opcode = 6'd43;
    cyc(); cyc(); bif.mem_ready = 1'b0; settle();
    chk("sw_addr", 32'(bif.state), 32'd2);
    cyc(); chk("sw_wr_memwrite", 32'(bif.mem_write), 32'd1);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("sw_wait%0d", i), 32'(bif.state), 32'd5);
      cyc();
    end
    chk("sw_to_state", 32'(bif.state), 32'd15);
    chk("sw_to_outs", 32'(all_outs()), 32'(18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1));
    bif.mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("err_sticky", 32'(bif.err), 32'd1);
    chk("err_state_sticky", 32'(bif.state), 32'd15);

    // Reset out of ERR.
    rst = 1'b1; settle();
    chk("err_rst_outs", 32'(all_outs()), 32'd0);
    chk("err_rst_state", 32'(bif.state), 32'd0);
    cyc(); rst = 1'b0; settle();

    // sw: ready arrives on the 15th MEM_WR cycle, ready wins over the trap.
    cyc(); cyc(); bif.mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("swr_wait%0d", i), 32'(bif.state), 32'd5);
      cyc();
    end
    bif.mem_ready = 1'b1; settle();
    chk("swr_last", 32'(bif.state), 32'd5);
    cyc(); chk("swr_fetch", 32'(bif.state), 32'd0);
    chk("swr_err", 32'(bif.err), 32'd0);

    // Opcode 2.
    bif.opcode = 6'd2;
    cyc(); chk("j_decode", 32'(bif.state), 32'd1);
    cyc();
`ifdef MC_CTRL_JUMP_EN
    chk("j_state", 32'(bif.state), 32'd9);
    chk("j_pcsrc", 32'(bif.pc_source), 32'd2);
    chk("j_pcwrite", 32'(bif.pc_write), 32'd1);
    cyc(); chk("j_done", 32'(bif.state), 32'd0);
`else
    chk("j_illegal_state", 32'(bif.state), 32'd15);
    chk("j_illegal_err", 32'(bif.err), 32'd1);
`endif
    rst = 1'b1; cyc(); rst = 1'b0; settle();

    // lw aborted by rst during MEM_RD.
    bif.opcode = 6'd35;
    cyc(); cyc(); bif.mem_ready = 1'b0;
    cyc(); chk("abort_rd_state", 32'(bif.state), 32'd3);
    #2; rst = 1'b1; settle();
    chk("abort_outs", 32'(all_outs()), 32'd0);
    chk("abort_state", 32'(bif.state), 32'd0);
    bif.mem_ready = 1'b1;
    cyc(); settle();
    chk("abort_hold_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0; settle();
    chk("abort_rel_state", 32'(bif.state), 32'd0);
    chk("abort_rel_memread", 32'(bif.mem_read), 32'd1);
    cyc(); chk("abort_next", 32'(bif.state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
